// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC fetch unit slice.
package pc_fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_e;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection and word-alignment check.
module pc_next_sel
  import pc_fetch_pkg::*;
(
  input  logic [31:0] pc_src_1_i,
  input  logic [31:0] branch_target_i,
  input  logic        pc_sel_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  always_comb begin
    next_pc_o    = pc_sel_i ? branch_target_i : pc_src_1_i;
    misaligned_o = |next_pc_o[1:0];
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Two-state fetch/execute sequencer owning the architectural PC, the
// registered instruction, the misalignment trap pulse and the retire counter.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_Src_1,
  input  logic [31:0] Branch_Target,
  input  logic        PC_Sel,
  input  logic        Stall,
  input  logic        Imem_Ready,
  input  logic [31:0] Imem_Rdata,
  output logic [31:0] PC_Current,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  output logic [31:0] Instr,
  output logic        Instr_Valid,
  output logic        Misalign_Trap,
  output logic [31:0] Retired_Count
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        trap_q, trap_d;
  logic [31:0] next_pc;
  logic        misaligned;

  pc_next_sel u_next_sel (
    .pc_src_1_i      (PC_Src_1),
    .branch_target_i (Branch_Target),
    .pc_sel_i        (PC_Sel),
    .next_pc_o       (next_pc),
    .misaligned_o    (misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: if (Imem_Ready) state_d = EXEC;
      EXEC:  if (!Stall)     state_d = FETCH;
    endcase
  end

  // Gated with rst so the handshake is quiet from the very first reset cycle.
  always_comb begin
    Imem_Req    = 1'b0;
    Instr_Valid = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: Imem_Req    = 1'b1;
        EXEC:  Instr_Valid = 1'b1;
      endcase
    end
  end

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    trap_d    = 1'b0;
    if (state_q == FETCH && Imem_Ready) begin
      instr_d = Imem_Rdata;
    end
    if (state_q == EXEC && !Stall) begin
      retired_d = retired_q + 32'd1;
      if (misaligned) begin
        pc_d   = TRAP_VECTOR;
        trap_d = 1'b1;
      end else begin
        pc_d = next_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_VECTOR;
      instr_q   <= NOP_INSTR;
      retired_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      trap_q    <= trap_d;
    end
  end

  assign PC_Current    = pc_q;
  assign Imem_Addr     = pc_q;
  assign Instr         = instr_q;
  assign Misalign_Trap = trap_q;
  assign Retired_Count = retired_q;

endmodule
